box_move_ctrl: RTL and testbench

//  Move-command scheduler between the PS/2 receiver and the box position datapath.

---
 rtl/box_pkg.sv | 40 ++++
 rtl/rr_arbiter4.sv | 30 +++
 rtl/box_move_ctrl.sv | 135 +++++++++++++
 tb/tb_box_move_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_pkg.sv
// rtl/box_pkg.sv - shared constants for the box move controller and position datapath
// Purpose: PS/2 scancodes, direction encoding, decoder state type, screen geometry.
// Ports:   none (package).
package box_pkg;

   localparam logic [7:0] SC_W  = 8'h1D;
   localparam logic [7:0] SC_A  = 8'h1C;
   localparam logic [7:0] SC_S  = 8'h1B;
   localparam logic [7:0] SC_D  = 8'h23;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_E0 = 8'hE0;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_LEFT  = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int PIX_WIDTH  = 640;
   localparam int PIX_HEIGHT = 480;
   localparam int PIX_STEP   = 8;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_BRK,
      DEC_EXT,
      DEC_EXT_BRK
   } dec_state_t;

   // {is_wasd, dir}
   function automatic logic [2:0] scan_to_dir(input logic [7:0] code);
      case (code)
         SC_W:    return {1'b1, DIR_UP};
         SC_A:    return {1'b1, DIR_LEFT};
         SC_S:    return {1'b1, DIR_DOWN};
         SC_D:    return {1'b1, DIR_RIGHT};
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin pick, combinational
// Purpose: grant the first set request after ptr, wrapping 3->0; ptr itself is searched last.
// Ports:   req[3:0] requests, ptr[1:0] last granted index,
//          grant[3:0] one-hot grant, grant_idx[1:0] its index, grant_any any request granted.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_any
);

   logic [1:0] cand;

   always_comb begin
      grant     = 4'b0000;
      grant_idx = ptr;
      grant_any = 1'b0;
      cand      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr + 2'(i);
         if (!grant_any && req[cand]) begin
            grant_any   = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/box_move_ctrl.sv
// rtl/box_move_ctrl.sv - WASD typematic move scheduler with round-robin move port
// Purpose: decode PS/2 make/break for W/A/S/D, generate frame-paced repeats,
//          and offer one pending direction at a time on a valid/ready port.
// Ports:   CLOCK, RESET (sync, active-high); kbd_byte/kbd_valid received bytes;
//          frame_tick frame strobe; move_valid/move_dir/move_ready move port;
//          keys_held held bitmap by dir; busy = pending or offering a move.
module box_move_ctrl
   import box_pkg::*;
#(
   parameter int REPEAT_DELAY = 15,
   parameter int REPEAT_RATE  = 3,
   parameter int CNT_W        = 5
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic [7:0] kbd_byte,
   input  logic       kbd_valid,
   input  logic       frame_tick,
   output logic       move_valid,
   output logic [1:0] move_dir,
   input  logic       move_ready,
   output logic [3:0] keys_held,
   output logic       busy
);

   dec_state_t state, state_nx;
   logic [2:0] code_hit;
   logic [3:0] key_sel;
   logic       make_ev, brk_ev;
   logic [3:0] held, opp_held, elig, pending;
   logic [1:0] ptr;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_any, pick;

   assign code_hit = scan_to_dir(kbd_byte);
   assign key_sel  = 4'b0001 << code_hit[1:0];

   always_ff @(posedge CLOCK) begin
      if (RESET) state <= DEC_IDLE;
      else       state <= state_nx;
   end

   // Extended sequences (E0 xx, E0 F0 xx) are consumed without producing events.
   always_comb begin
      state_nx = state;
      make_ev  = 1'b0;
      brk_ev   = 1'b0;
      if (kbd_valid) begin
         case (state)
            DEC_IDLE: begin
               if (kbd_byte == SC_F0)      state_nx = DEC_BRK;
               else if (kbd_byte == SC_E0) state_nx = DEC_EXT;
               else                        make_ev  = code_hit[2];
            end
            DEC_BRK: begin
               brk_ev   = code_hit[2];
               state_nx = DEC_IDLE;
            end
            DEC_EXT:     state_nx = (kbd_byte == SC_F0) ? DEC_EXT_BRK : DEC_IDLE;
            DEC_EXT_BRK: state_nx = DEC_IDLE;
            default:     state_nx = DEC_IDLE;
         endcase
      end
   end

   // Opposite of dir d is d^2 (UP/DOWN, LEFT/RIGHT).
   assign opp_held = {held[1], held[0], held[3], held[2]};

   for (genvar d = 0; d < 4; d++) begin : g_key
      logic             held_r, first_r;
      logic [CNT_W-1:0] cnt;

      assign held[d] = held_r;
      assign elig[d] = frame_tick && held_r && (cnt == '0) && !opp_held[d];

      // Make/break win over the frame update; a key made this cycle was not
      // held when the tick was sampled, so it waits for the next tick.
      always_ff @(posedge CLOCK) begin
         if (RESET) begin
            held_r  <= 1'b0;
            first_r <= 1'b0;
            cnt     <= '0;
         end else if (make_ev && key_sel[d] && !held_r) begin
            held_r  <= 1'b1;
            first_r <= 1'b1;
            cnt     <= '0;
         end else if (brk_ev && key_sel[d]) begin
            held_r  <= 1'b0;
            first_r <= 1'b0;
            cnt     <= '0;
         end else if (frame_tick && held_r) begin
            if (cnt == '0) begin
               cnt     <= first_r ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);
               first_r <= 1'b0;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   rr_arbiter4 u_arb (
      .req       (pending),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Only pick while the port is empty, so issue rate is at most one per 2 cycles.
   assign pick = !move_valid && grant_any;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pending    <= 4'b0000;
         ptr        <= 2'd3;
         move_valid <= 1'b0;
         move_dir   <= 2'd0;
      end else begin
         pending <= (pending & ~(grant & {4{pick}})) | elig;
         if (pick) begin
            move_valid <= 1'b1;
            move_dir   <= grant_idx;
            ptr        <= grant_idx;
         end else if (move_valid && move_ready) begin
            move_valid <= 1'b0;
         end
      end
   end

   assign keys_held = held;
   assign busy      = (|pending) || move_valid;

endmodule

// File: tb/tb_box_move_ctrl.sv
// tb/tb_box_move_ctrl.sv - self-checking bench for box_move_ctrl
module tb_box_move_ctrl;

   localparam int RD = 15;
   localparam int RR = 3;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] kbd_byte = 8'h00;
   logic       kbd_valid = 1'b0;
   logic       frame_tick = 1'b0;
   logic       move_ready = 1'b0;
   logic       move_valid;
   logic [1:0] move_dir;
   logic [3:0] keys_held;
   logic       busy;

   always #5 CLOCK = ~CLOCK;

   box_move_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(5)) dut (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
      .kbd_byte   (kbd_byte),
      .kbd_valid  (kbd_valid),
      .frame_tick (frame_tick),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .keys_held  (keys_held),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per key, count frames seen while held; a key moves on
   // frame 1, frame RD+1, and every RR frames after that.
   bit [3:0] m_held;
   int       m_frames[4];
   bit [3:0] m_pend;
   bit       m_valid;
   int       m_dir;
   int       m_ptr;
   bit       m_brk, m_ext;

   int ntick;
   int mv_dir_q[$];
   int mv_tick_q[$];

   typedef struct {
      bit         kv;
      logic [7:0] b;
      bit         tk;
      bit         rdy;
      bit         ev;
      int         ed;
      logic [3:0] eh;
      bit         eb;
   } vec_t;

   vec_t tbl[12];

   function automatic bit is_move(int n);
      return (n == 1) || (n > RD && ((n - 1 - RD) % RR) == 0);
   endfunction

   function automatic int dir_of(logic [7:0] b);
      case (b)
         8'h1D:   return 0;
         8'h1C:   return 1;
         8'h1B:   return 2;
         8'h23:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit [3:0] elig;
      int d;
      if (RESET) begin
         m_held = '0; m_pend = '0; m_valid = 0; m_dir = 0; m_ptr = 3;
         m_brk = 0; m_ext = 0;
         for (int k = 0; k < 4; k++) m_frames[k] = 0;
         return;
      end
      elig = '0;
      for (int k = 0; k < 4; k++)
         if (frame_tick && m_held[k] && !m_held[k ^ 2] && is_move(m_frames[k] + 1)) elig[k] = 1;
      for (int k = 0; k < 4; k++)
         if (frame_tick && m_held[k]) m_frames[k]++;
      if (!m_valid && m_pend != 0) begin
         for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (!m_valid && m_pend[c]) begin
               m_pend[c] = 0; m_valid = 1; m_dir = c; m_ptr = c;
            end
         end
      end else if (m_valid && move_ready) begin
         m_valid = 0;
      end
      m_pend |= elig;
      if (kbd_valid) begin
         d = dir_of(kbd_byte);
         if (m_ext) begin
            if (kbd_byte == 8'hF0 && !m_brk) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
         end else if (m_brk) begin
            m_brk = 0;
            if (d >= 0) begin m_held[d] = 0; m_frames[d] = 0; end
         end else if (kbd_byte == 8'hF0) m_brk = 1;
         else if (kbd_byte == 8'hE0) m_ext = 1;
         else if (d >= 0 && !m_held[d]) begin m_held[d] = 1; m_frames[d] = 0; end
      end
   endtask

   task automatic step(input bit rst, input bit kv, input logic [7:0] b, input bit tk, input bit rdy);
      RESET = rst; kbd_valid = kv; kbd_byte = b; frame_tick = tk; move_ready = rdy;
      if (!rst && tk) ntick++;
      if (!rst && move_valid === 1'b1 && rdy) begin
         mv_dir_q.push_back(int'(move_dir));
         mv_tick_q.push_back(ntick);
      end
      model_step();
      @(posedge CLOCK);
      #1;
      check("model_valid", int'(move_valid), int'(m_valid));
      if (m_valid) check("model_dir", int'(move_dir), m_dir);
      check("model_held", int'(keys_held), int'(m_held));
      check("model_busy", int'(busy), int'((m_pend != 0) || m_valid));
   endtask

   task automatic key(input logic [7:0] b, input bit rdy);
      step(0, 1, b, 0, rdy);
   endtask

   task automatic tick(input bit rdy);
      step(0, 0, 8'h00, 1, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, rdy);
   endtask

   task automatic do_reset();
      step(1, 0, 8'h00, 0, 1);
      step(1, 0, 8'h00, 0, 1);
      mv_dir_q.delete();
      mv_tick_q.delete();
      ntick = 0;
   endtask

   initial begin
      int exp_t[3];
      logic [7:0] codes[8];

      tbl[0]  = '{1, 8'h1D, 0, 1, 0, 0, 4'b0001, 0};
      tbl[1]  = '{0, 8'h00, 1, 1, 0, 0, 4'b0001, 1};
      tbl[2]  = '{0, 8'h00, 0, 1, 1, 0, 4'b0001, 1};
      tbl[3]  = '{0, 8'h00, 0, 1, 0, 0, 4'b0001, 0};
      tbl[4]  = '{1, 8'hF0, 0, 1, 0, 0, 4'b0001, 0};
      tbl[5]  = '{1, 8'h1D, 0, 1, 0, 0, 4'b0000, 0};
      tbl[6]  = '{0, 8'h00, 1, 1, 0, 0, 4'b0000, 0};
      tbl[7]  = '{1, 8'h1C, 1, 1, 0, 0, 4'b0010, 0};
      tbl[8]  = '{0, 8'h00, 1, 0, 0, 0, 4'b0010, 1};
      tbl[9]  = '{0, 8'h00, 0, 0, 1, 1, 4'b0010, 1};
      tbl[10] = '{0, 8'h00, 0, 0, 1, 1, 4'b0010, 1};
      tbl[11] = '{0, 8'h00, 0, 1, 0, 0, 4'b0010, 0};

      // Reset state
      do_reset();
      check("rst_valid", int'(move_valid), 0);
      check("rst_dir", int'(move_dir), 0);
      check("rst_held", int'(keys_held), 0);
      check("rst_busy", int'(busy), 0);

      // Table vectors
      for (int i = 0; i < 12; i++) begin
         step(0, tbl[i].kv, tbl[i].b, tbl[i].tk, tbl[i].rdy);
         check($sformatf("tbl%0d_valid", i), int'(move_valid), int'(tbl[i].ev));
         if (tbl[i].ev) check($sformatf("tbl%0d_dir", i), int'(move_dir), tbl[i].ed);
         check($sformatf("tbl%0d_held", i), int'(keys_held), int'(tbl[i].eh));
         check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      end

      // 1: typematic timing of a single held key
      do_reset();
      key(8'h1D, 1);
      check("t1_held", int'(keys_held), 1);
      for (int i = 0; i < 20; i++) begin tick(1); idle(4, 1); end
      exp_t[0] = 1; exp_t[1] = 16; exp_t[2] = 19;
      check("t1_nmoves", mv_dir_q.size(), 3);
      if (mv_dir_q.size() == 3)
         for (int i = 0; i < 3; i++) begin
            check("t1_dir", mv_dir_q[i], 0);
            check("t1_tick", mv_tick_q[i], exp_t[i]);
         end

      // 2: press and release before any tick
      do_reset();
      key(8'h1D, 1); key(8'hF0, 1); key(8'h1D, 1);
      tick(1); idle(4, 1);
      check("t2_nmoves", mv_dir_q.size(), 0);
      check("t2_held", int'(keys_held), 0);
      check("t2_busy", int'(busy), 0);

      // 3: opposite keys cancel, counters keep running
      do_reset();
      key(8'h1C, 1); key(8'h23, 1);
      for (int i = 0; i < 30; i++) begin tick(1); idle(2, 1); end
      check("t3_cancel", mv_dir_q.size(), 0);
      key(8'hF0, 1); key(8'h23, 1);
      tick(1); idle(4, 1);
      check("t3_nmoves", mv_dir_q.size(), 1);
      if (mv_dir_q.size() == 1) check("t3_dir", mv_dir_q[0], 1);

      // 4: back-pressure holds move_dir stable, then round-robin order
      do_reset();
      key(8'h1D, 1); key(8'h1C, 1);
      tick(0);
      for (int i = 0; i < 10; i++) begin
         idle(1, 0);
         check("t4_hold_valid", int'(move_valid), 1);
         check("t4_hold_dir", int'(move_dir), 0);
      end
      idle(6, 1);
      check("t4_nmoves", mv_dir_q.size(), 2);
      if (mv_dir_q.size() == 2) begin
         check("t4_first", mv_dir_q[0], 0);
         check("t4_second", mv_dir_q[1], 1);
      end

      // 5: extended keys and unrelated codes are ignored
      do_reset();
      key(8'hE0, 1); key(8'h1D, 1); key(8'hE0, 1); key(8'hF0, 1); key(8'h1D, 1); key(8'h12, 1);
      check("t5_held", int'(keys_held), 0);
      tick(1); idle(4, 1);
      check("t5_nmoves", mv_dir_q.size(), 0);

      // 6: reset while a move is in flight and LEFT/RIGHT are pending
      do_reset();
      key(8'h1C, 0); tick(0); idle(2, 0);
      key(8'hF0, 0); key(8'h1C, 0); key(8'h23, 0); tick(0); idle(1, 0);
      key(8'hF0, 0); key(8'h23, 0); key(8'h1C, 0); tick(0); idle(1, 0);
      check("t6_pre_valid", int'(move_valid), 1);
      check("t6_pre_dir", int'(move_dir), 1);
      check("t6_pre_busy", int'(busy), 1);
      step(1, 0, 8'h00, 0, 0);
      check("t6_valid", int'(move_valid), 0);
      check("t6_dir", int'(move_dir), 0);
      check("t6_held", int'(keys_held), 0);
      check("t6_busy", int'(busy), 0);
      mv_dir_q.delete(); mv_tick_q.delete();
      tick(1); idle(4, 1);
      check("t6_nmoves", mv_dir_q.size(), 0);

      // Random traffic against the model
      codes[0] = 8'h1D; codes[1] = 8'h1C; codes[2] = 8'h1B; codes[3] = 8'h23;
      codes[4] = 8'hF0; codes[5] = 8'hE0; codes[6] = 8'h12; codes[7] = 8'hF0;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 3) == 0),
              codes[$urandom_range(0, 7)],
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
